// File: rtl/cpu_sequencer.sv
// Fetch/decode sequencer: fetches 8-bit instructions over req/ack, latches the
// opcode for the control ROM, steps the PC, and handles JMP/HALT locally.
module cpu_sequencer #(
  parameter int PC_WIDTH = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  output logic                imem_req,
  output logic [PC_WIDTH-1:0] imem_addr,
  input  logic                imem_ack,
  input  logic [7:0]          imem_data,
  output logic [2:0]          rom_addr,
  output logic [4:0]          operand,
  output logic                exec_en,
  output logic                busy,
  output logic                halted
);

  localparam logic [2:0] OP_JMP  = 3'd6;
  localparam logic [2:0] OP_HALT = 3'd7;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_HALT   = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic [PC_WIDTH-1:0]   pc_q, pc_d;
  logic [7:0]            ir_q, ir_d;
  logic [PC_WIDTH-1:0]   jmp_pc;

  // The 5-bit operand is zero-extended or truncated to the PC width.
  if (PC_WIDTH > 5) begin : g_jmp_ext
    assign jmp_pc = {{(PC_WIDTH-5){1'b0}}, ir_q[4:0]};
  end else if (PC_WIDTH == 5) begin : g_jmp_eq
    assign jmp_pc = ir_q[4:0];
  end else begin : g_jmp_trunc
    assign jmp_pc = ir_q[PC_WIDTH-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) state_d = S_FETCH;
      end
      S_FETCH: begin
        if (imem_ack) begin
          ir_d    = imem_data;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        unique case (ir_q[7:5])
          OP_HALT: state_d = S_HALT;
          OP_JMP: begin
            pc_d    = jmp_pc;
            state_d = S_FETCH;
          end
          default: state_d = S_EXEC;
        endcase
      end
      S_EXEC: begin
        pc_d    = pc_q + PC_WIDTH'(1);
        state_d = S_FETCH;
      end
      S_HALT: begin
        if (start) begin
          pc_d    = '0;
          state_d = S_FETCH;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Strobes depend on the state register alone, never on start/ack.
  assign imem_req  = (state_q == S_FETCH);
  assign imem_addr = pc_q;
  assign exec_en   = (state_q == S_EXEC);
  assign busy      = (state_q == S_FETCH) || (state_q == S_DECODE) || (state_q == S_EXEC);
  assign halted    = (state_q == S_HALT);
  assign rom_addr  = ir_q[7:5];
  assign operand   = ir_q[4:0];

endmodule

// File: tb/tb_cpu_sequencer.sv
// Scoreboard bench for cpu_sequencer: a program-walk model predicts fetch/exec/halt
// events, a memory responder inserts random wait states, a monitor checks events.
module tb_cpu_sequencer;
  localparam int PW = 5;
  localparam int MEMSZ = 1 << PW;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          imem_req;
  logic [PW-1:0] imem_addr;
  logic          imem_ack = 1'b0;
  logic [7:0]    imem_data = 8'h00;
  logic [2:0]    rom_addr;
  logic [4:0]    operand;
  logic          exec_en;
  logic          busy;
  logic          halted;

  cpu_sequencer #(.PC_WIDTH(PW)) dut (
    .clk(clk), .rst(rst), .start(start),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_data(imem_data),
    .rom_addr(rom_addr), .operand(operand), .exec_en(exec_en), .busy(busy), .halted(halted)
  );

  always #5 clk = ~clk;

  typedef enum int {EV_FETCH = 0, EV_EXEC = 1, EV_HALT = 2} ev_kind_t;
  typedef struct {
    ev_kind_t kind;
    int       val;
    int       gap;
  } ev_t;

  ev_t        exp_q[$];
  logic [7:0] mem [0:MEMSZ-1];
  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int last_ref = 0;
  int force_delay = -1;
  int cur_delay = 0;
  bit mon_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic pop_ev(input ev_kind_t k, input string nm, output ev_t ev, output bit ok);
    ok = 1'b0;
    ev = '{EV_HALT, 0, 0};
    n_chk++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL %s: got DUT event kind %0d, expected no event (cycle %0d)", nm, k, cyc);
    end else begin
      ev = exp_q.pop_front();
      if (ev.kind != k) begin
        n_fail++;
        $display("FAIL %s: got event kind %0d, expected kind %0d (cycle %0d)", nm, k, ev.kind, cyc);
      end else ok = 1'b1;
    end
  endtask

  // Instruction memory with random wait states and spurious acks while idle.
  initial begin : responder
    bit new_req;
    int cnt;
    new_req = 1'b1;
    cnt = 0;
    forever begin
      @(posedge clk);
      #1;
      if (rst || !imem_req) begin
        cnt = 0;
        new_req = 1'b1;
        imem_ack = ($urandom_range(0, 3) == 0);
        imem_data = 8'($urandom);
      end else begin
        if (new_req) begin
          cur_delay = (force_delay >= 0) ? force_delay : int'($urandom_range(0, 2));
          new_req = 1'b0;
        end
        if (cnt >= cur_delay) begin
          imem_ack = 1'b1;
          imem_data = mem[imem_addr];
        end else begin
          imem_ack = 1'b0;
          imem_data = 8'($urandom);
          cnt++;
        end
      end
    end
  end

  // Monitor: compares every DUT event against the scoreboard.
  bit            p_req = 1'b0, p_exec = 1'b0, p_halt = 1'b0, p_fetch_ack = 1'b0;
  logic [PW-1:0] p_addr = '0;
  logic [2:0]    p_rom = '0;
  int            req_len = 0;

  always @(negedge clk) begin : monitor
    ev_t ev;
    bit  ok;
    if (imem_req) req_len = p_req ? req_len + 1 : 1;
    else req_len = 0;
    if (mon_en) begin
      if (imem_req && !p_req) begin
        pop_ev(EV_FETCH, "fetch_event", ev, ok);
        if (ok) begin
          check("fetch_addr", int'(imem_addr), ev.val);
          check("fetch_latency", cyc - last_ref, ev.gap);
        end
      end
      if (imem_req && p_req) check("fetch_addr_stable", int'(imem_addr), int'(p_addr));
      if (exec_en) begin
        check("exec_single_cycle", int'(p_exec), 0);
        pop_ev(EV_EXEC, "exec_event", ev, ok);
        if (ok) begin
          check("exec_rom_addr", int'(rom_addr), ev.val / 32);
          check("exec_operand", int'(operand), ev.val % 32);
          check("exec_latency", cyc - last_ref, ev.gap);
        end
      end
      if (halted && !p_halt) begin
        pop_ev(EV_HALT, "halt_event", ev, ok);
        if (ok) check("halt_latency", cyc - last_ref, ev.gap);
      end
      if (rom_addr != p_rom) check("rom_addr_changes_only_leaving_fetch", int'(p_fetch_ack), 1);
      check("halted_and_busy_exclusive", int'(halted && busy), 0);
      if (imem_req && imem_ack) begin
        check("fetch_wait_cycles", req_len, cur_delay + 1);
        last_ref = cyc;
      end
    end
    p_fetch_ack = imem_req && imem_ack;
    p_req  = imem_req;
    p_exec = exec_en;
    p_halt = halted;
    p_addr = imem_addr;
    p_rom  = rom_addr;
  end

  // Reference model: walk the program from address 0 until HALT.
  function automatic void model_walk();
    int pc;
    int gap;
    pc = 0;
    gap = 1;
    for (int s = 0; s < 64; s++) begin
      int ins;
      int op;
      int opd;
      ins = int'(mem[pc]);
      op  = ins / 32;
      opd = ins % 32;
      exp_q.push_back('{EV_FETCH, pc, gap});
      if (op == 7) begin
        exp_q.push_back('{EV_HALT, 0, 2});
        return;
      end
      if (op == 6) begin
        pc  = opd % MEMSZ;
        gap = 2;
      end else begin
        exp_q.push_back('{EV_EXEC, ins, 2});
        pc  = (pc + 1) % MEMSZ;
        gap = 3;
      end
    end
  endfunction

  // Random terminating program: a path of distinct addresses ending in HALT.
  function automatic void gen_random();
    bit visited [0:MEMSZ-1];
    int pc;
    int len;
    pc = 0;
    len = int'($urandom_range(2, 14));
    for (int i = 0; i < MEMSZ; i++) begin
      mem[i] = 8'($urandom);
      visited[i] = 1'b0;
    end
    visited[0] = 1'b1;
    for (int k = 0; k < len; k++) begin
      int nxt;
      bit jmp;
      if (k == len - 1) begin
        mem[pc] = 8'(224 + $urandom_range(0, 31));
        return;
      end
      jmp = ($urandom_range(0, 3) == 0) || visited[(pc + 1) % MEMSZ];
      if (jmp) begin
        nxt = int'($urandom_range(0, MEMSZ - 1));
        while (visited[nxt]) nxt = (nxt + 1) % MEMSZ;
        mem[pc] = 8'(192 + nxt);
      end else begin
        nxt = (pc + 1) % MEMSZ;
        mem[pc] = 8'($urandom_range(0, 5) * 32 + $urandom_range(0, 31));
      end
      visited[nxt] = 1'b1;
      pc = nxt;
    end
  endfunction

  task automatic fill_mem(input logic [7:0] v);
    for (int i = 0; i < MEMSZ; i++) mem[i] = v;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_imem_req"}, int'(imem_req), 0);
    check({tag, "_imem_addr"}, int'(imem_addr), 0);
    check({tag, "_rom_addr"}, int'(rom_addr), 0);
    check({tag, "_operand"}, int'(operand), 0);
    check({tag, "_exec_en"}, int'(exec_en), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_halted"}, int'(halted), 0);
  endtask

  task automatic pulse_start();
    @(posedge clk);
    #1;
    start = 1'b1;
    last_ref = cyc;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Waits for HALT, injecting ignored start pulses while busy.
  task automatic wait_halt(input int max_cyc);
    bit done;
    done = 1'b0;
    for (int i = 0; i < max_cyc && !done; i++) begin
      @(posedge clk);
      #1;
      if (halted) done = 1'b1;
      else start = ($urandom_range(0, 7) == 0);
    end
    start = 1'b0;
    check("program_halts", int'(done), 1);
    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_drained", exp_q.size(), 0);
    check("no_req_after_halt", int'(imem_req), 0);
    exp_q.delete();
  endtask

  task automatic run_prog();
    model_walk();
    pulse_start();
    wait_halt(400);
  endtask

  initial begin : main
    bit found;
    fill_mem(8'hE0);
    #1 rst = 1'b1;
    #1 check_all_zero("reset_async");
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1 start = 1'($urandom);
      @(negedge clk);
      check_all_zero("reset_held");
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("idle_no_req", int'(imem_req), 0);
    check("idle_not_busy", int'(busy), 0);
    check("idle_not_halted", int'(halted), 0);
    mon_en = 1'b1;

    // Straight-line program
    fill_mem(8'hE0);
    mem[0] = 8'h20; mem[1] = 8'h60; mem[2] = 8'hE0;
    run_prog();

    // Wait states
    fill_mem(8'hE0);
    mem[0] = 8'h40;
    force_delay = 4;
    run_prog();
    force_delay = -1;

    // Jump
    fill_mem(8'h00);
    mem[0] = 8'hC3; mem[3] = 8'h40; mem[4] = 8'hE0;
    run_prog();

    // PC wrap, then restart from HALT
    fill_mem(8'h00);
    mem[0] = 8'hDF; mem[31] = 8'h00;
    exp_q.push_back('{EV_FETCH, 0, 1});
    exp_q.push_back('{EV_FETCH, 31, 2});
    exp_q.push_back('{EV_EXEC, 0, 2});
    exp_q.push_back('{EV_FETCH, 0, 3});
    exp_q.push_back('{EV_HALT, 0, 2});
    pulse_start();
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      @(negedge clk);
      if (imem_req && imem_ack) found = 1'b1;
    end
    check("wrap_first_ack_seen", int'(found), 1);
    #1 mem[0] = 8'hE0;
    wait_halt(200);
    exp_q.push_back('{EV_FETCH, 0, 1});
    exp_q.push_back('{EV_HALT, 0, 2});
    pulse_start();
    wait_halt(200);

    // Random programs
    for (int p = 0; p < 20; p++) begin
      gen_random();
      run_prog();
    end

    // Async reset while a fetch is pending
    mon_en = 1'b0;
    fill_mem(8'h20);
    force_delay = 10;
    pulse_start();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("fetch_pending_before_reset", int'(imem_req), 1);
    #1 rst = 1'b1;
    #1 check_all_zero("reset_mid_fetch");
    @(posedge clk);
    #1 rst = 1'b0;
    force_delay = -1;
    repeat (3) @(posedge clk);
    #1 check_all_zero("idle_after_fetch_reset");

    // Async reset during EXEC
    fill_mem(8'hE0);
    mem[0] = 8'h20;
    pulse_start();
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      @(negedge clk);
      if (exec_en) found = 1'b1;
    end
    check("exec_reached_before_reset", int'(found), 1);
    #1 rst = 1'b1;
    #1 check_all_zero("reset_mid_exec");
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("no_exec_after_reset", int'(exec_en), 0);
      check("idle_after_exec_reset", int'(busy || halted), 0);
    end
    exp_q.delete();
    mon_en = 1'b1;

    // Normal operation resumes from IDLE
    gen_random();
    run_prog();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got simulation time limit, expected completion");
    $fatal(1);
  end

endmodule

// File: doc/cpu_sequencer.md
# cpu_sequencer

Fetch/decode sequencer for the CPU controller. It sits directly upstream of the control ROM. It fetches 8-bit instructions from instruction memory over a req/ack handshake and latches the 3-bit opcode that addresses the control ROM. It steps a program counter, handles jump and halt opcodes locally, and emits a one-cycle execute strobe that qualifies the ROM's control word for the datapath.

## Interface
- PC_WIDTH, 5, program counter / instruction-memory address width
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- start  input  1  begin (or restart) execution; honoured only in IDLE or HALT
- imem_req  output  1  instruction fetch request
- imem_addr  output  PC_WIDTH  fetch address (equals PC)
- imem_ack  input  1  fetch complete; imem_data valid this cycle
- imem_data  input  8  instruction word: [7:5] opcode, [4:0] operand
- rom_addr  output  3  opcode to control ROM (IR[7:5])
- operand  output  5  IR[4:0]
- exec_en  output  1  one-cycle strobe: the ROM control word applies this cycle
- busy  output  1  high in FETCH, DECODE, EXEC
- halted  output  1  high in HALT

## Operation
- Registers: state, pc[PC_WIDTH-1:0], ir[7:0].
- rom_addr = ir[7:5] and operand = ir[4:0] at all times.
- Opcode map:
  - 0–5 are ALU ops, decoded by the control ROM.
  - 6 = JMP: pc <= operand, truncated or zero-extended to PC_WIDTH.
  - 7 = HALT.
- The ROM outputs a control word with load=1 for opcode 0. The datapath must AND load with exec_en; exec_en is the only qualifier for executing.
- States:
  - IDLE:
    - Outputs low.
    - start=1 -> FETCH.
  - FETCH:
    - imem_req=1, imem_addr=pc.
    - Stay until imem_ack=1.
    - On ack: ir <= imem_data, -> DECODE.
  - DECODE:
    - One cycle; rom_addr is stable with the new opcode.
    - opcode 7 -> HALT.
    - opcode 6 -> pc <= operand, -> FETCH.
    - Else -> EXEC.
  - EXEC:
    - exec_en=1 for exactly this cycle.
    - pc <= pc+1, modulo 2^PC_WIDTH.
    - -> FETCH.
  - HALT:
    - halted=1.
    - start=1 -> pc <= 0, -> FETCH.
- imem_ack outside FETCH is ignored. start outside IDLE/HALT is ignored.
- imem_req, exec_en, busy and halted are decoded from the state register only, with no input-to-output combinational path.

## Timing
- Reset (asynchronous, takes effect immediately with no clock edge):
  - state=IDLE, pc=0, ir=0.
  - imem_req=0, imem_addr=0, rom_addr=0, operand=0, exec_en=0, busy=0, halted=0.
- Zero-wait memory (ack in the first FETCH cycle):
  - ALU instruction: 3 cycles (FETCH, DECODE, EXEC); exec_en pulses every 3rd cycle for back-to-back ALU ops.
  - JMP: 2 cycles.
  - HALT: 2 cycles to halted=1.
- Each memory wait cycle adds one FETCH cycle. imem_addr and imem_req stay stable until ack.
- Start latency: start sampled high in IDLE -> imem_req=1 on the next cycle.
- rom_addr changes only on the clock edge that leaves FETCH. It is stable for the whole DECODE and EXEC cycles.
- PC wrap: an EXEC at pc=2^PC_WIDTH-1 makes the next fetch address 0. JMP with an operand wider than PC_WIDTH keeps only the low PC_WIDTH bits.
- Reset asserted mid-operation (any state, including FETCH with req pending) aborts immediately. No exec_en is emitted after reset asserts.

## Test plan
- Reset: hold rst, toggle inputs -> every output 0. Release and wait 5 cycles without start -> still IDLE, imem_req=0.
- Straight-line program, zero-wait memory, mem[0]=0x20, mem[1]=0x60, mem[2]=0xE0, pulse start:
  - Fetch addresses 0, 1, 2.
  - exec_en with rom_addr=1, then exec_en with rom_addr=3, exactly 3 cycles apart.
  - halted=1 two cycles after the third fetch ack; no further imem_req.
- Wait states: ack delayed 4 cycles on mem[0]=0x40 -> imem_req high for 5 cycles with imem_addr=0, no exec_en. exec_en with rom_addr=2 follows 2 cycles after ack.
- Jump: mem[0]=0xC3, mem[3]=0x40, mem[4]=0xE0 -> fetch addresses 0, 3, 4. Exactly one exec_en (rom_addr=2), then halted.
- Wrap and restart: PC_WIDTH=5, JMP to 31, mem[31]=0x00, mem[0]=0xE0 -> exec_en at pc 31, next fetch address 0, then HALT. Pulse start -> fetch restarts at address 0.
- Async reset asserted mid-FETCH and again mid-EXEC -> outputs 0 before the next clock edge. exec_en drops and state returns to IDLE.
